// File: rtl/inv_operand_fifo_if.sv
// rtl/inv_operand_fifo_if.sv - producer/consumer handshake bundle for the inverter operand FIFO
interface inv_operand_fifo_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  out_data,
      input  out_valid,
      output out_ready
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output out_data,
      output out_valid,
      input  out_ready
   );
endinterface

// File: rtl/inv_operand_fifo.sv
// rtl/inv_operand_fifo.sv - in-order operand buffer feeding the 8-bit inverter stage
module inv_operand_fifo #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   inv_operand_fifo_if.slave   bus,
   output logic [ADDR_W:0]     count,
   output logic                overflow
);
   localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              do_write;
   logic              do_read;

   // Flags come from count alone, so a read never opens a same-cycle write slot.
   assign bus.in_ready  = (count != FULL_COUNT);
   assign bus.out_valid = (count != '0);
   assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;

   assign do_write = bus.in_valid && bus.in_ready && !flush;
   assign do_read  = bus.out_valid && bus.out_ready && !flush;

   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[wr_ptr] <= bus.in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (bus.in_valid && (count == FULL_COUNT)) begin
            overflow <= 1'b1;
         end
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (do_write) begin
               wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (do_read) begin
               rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({do_write, do_read})
               2'b10:   count <= count + (ADDR_W + 1)'(1);
               2'b01:   count <= count - (ADDR_W + 1)'(1);
               default: count <= count;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_inv_operand_fifo.sv
// tb/tb_inv_operand_fifo.sv - randomized self-checking bench for inv_operand_fifo
module tb_inv_operand_fifo;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   logic [2:0] count;
   logic       overflow;
   int         checks = 0;
   int         errors = 0;

   logic [7:0] q[$];
   logic       m_ovf;

   inv_operand_fifo_if #(.WIDTH(8)) bus ();

   inv_operand_fifo #(.WIDTH(8), .DEPTH(DEPTH), .ADDR_W(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .bus      (bus),
      .count    (count),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic cycle(input logic rn, input logic fl, input logic iv,
                        input logic [7:0] id, input logic ordy);
      int sz;
      rst_n         = rn;
      flush         = fl;
      bus.in_valid  = iv;
      bus.in_data   = id;
      bus.out_ready = ordy;
      sz = q.size();
      if (!rn) begin
         q.delete();
         m_ovf = 1'b0;
      end else begin
         if (iv && sz == DEPTH) m_ovf = 1'b1;
         if (fl) begin
            q.delete();
         end else begin
            if (ordy && sz != 0) void'(q.pop_front());
            if (iv && sz != DEPTH) q.push_back(id);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", bus.out_data); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
   endtask

   task automatic test_fill_drain();
      logic [7:0] vals [4] = '{8'h00, 8'h0F, 8'hA5, 8'hFF};
      logic [7:0] invs [4] = '{8'hFF, 8'hF0, 8'h5A, 8'h00};
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, vals[i], 1'b0);
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d want 4", count); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b want 0", bus.in_ready); end
      checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL fill_head: got %h want 00", bus.out_data); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (bus.out_data !== vals[i]) begin errors++; $display("FAIL drain_data[%0d]: got %h want %h", i, bus.out_data, vals[i]); end
         checks++; if (~bus.out_data !== invs[i]) begin errors++; $display("FAIL drain_inverted[%0d]: got %h want %h", i, ~bus.out_data, invs[i]); end
         cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_count: got %0d want 0", count); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain_out_valid: got %b want 0", bus.out_valid); end
   endtask

   task automatic test_back_to_back();
      cycle(1'b1, 1'b0, 1'b1, 8'h11, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 8'h22, 1'b0);
      checks++; if (bus.out_data !== 8'h11) begin errors++; $display("FAIL b2b_head0: got %h want 11", bus.out_data); end
      cycle(1'b1, 1'b0, 1'b1, 8'h33, 1'b1);
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count: got %0d want 2", count); end
      checks++; if (bus.out_data !== 8'h22) begin errors++; $display("FAIL b2b_head1: got %h want 22", bus.out_data); end
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      checks++; if (bus.out_data !== 8'h33) begin errors++; $display("FAIL b2b_head2: got %h want 33", bus.out_data); end
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_empty: got %0d want 0", count); end
   endtask

   task automatic test_overflow_wrap();
      logic [7:0] order [4] = '{8'h03, 8'h04, 8'h06, 8'h07};
      for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b0, 1'b1, 8'(i), 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 8'h05, 1'b0);
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d want 4", count); end
      cycle(1'b1, 1'b0, 1'b1, 8'h05, 1'b1);
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_read_count: got %0d want 3", count); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_read_ready: got %b want 1", bus.in_ready); end
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      cycle(1'b1, 1'b0, 1'b1, 8'h06, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 8'h07, 1'b0);
      for (int i = 0; i < 4; i++) begin
         checks++; if (bus.out_data !== order[i]) begin errors++; $display("FAIL wrap_data[%0d]: got %h want %h", i, bus.out_data, order[i]); end
         cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      end
   endtask

   task automatic test_flush_reset();
      cycle(1'b1, 1'b0, 1'b1, 8'hAA, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 8'hBB, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 8'hCC, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 8'h99, 1'b1);
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d want 0", count); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b want 0", bus.out_valid); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL flush_keeps_ovf: got %b want 1", overflow); end
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_clears_ovf: got %b want 0", overflow); end
   endtask

   task automatic test_empty_simultaneous();
      cycle(1'b1, 1'b0, 1'b1, 8'hC3, 1'b1);
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL empty_rw_valid: got %b want 1", bus.out_valid); end
      checks++; if (bus.out_data !== 8'hC3) begin errors++; $display("FAIL empty_rw_data: got %h want c3", bus.out_data); end
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL empty_rw_count: got %0d want 1", count); end
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
   endtask

   task automatic test_random();
      logic [7:0] exp_data;
      for (int n = 0; n < 400; n++) begin
         cycle(($urandom_range(0, 63) != 0), ($urandom_range(0, 31) == 0),
               1'($urandom), 8'($urandom), 1'($urandom));
         exp_data = (q.size() != 0) ? q[0] : 8'h00;
         checks++; if (count !== 3'(q.size())) begin errors++; $display("FAIL rnd_count@%0d: got %0d want %0d", n, count, q.size()); end
         checks++; if (bus.out_data !== exp_data) begin errors++; $display("FAIL rnd_data@%0d: got %h want %h", n, bus.out_data, exp_data); end
         checks++; if (bus.out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", n, bus.out_valid, q.size() != 0); end
         checks++; if (bus.in_ready !== (q.size() != DEPTH)) begin errors++; $display("FAIL rnd_ready@%0d: got %b want %b", n, bus.in_ready, q.size() != DEPTH); end
         checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_overflow@%0d: got %b want %b", n, overflow, m_ovf); end
      end
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
      m_ovf = 1'b0;
      test_reset();
      test_fill_drain();
      test_back_to_back();
      test_overflow_wrap();
      test_flush_reset();
      test_empty_simultaneous();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
